// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC owner and fetch sequencer sharing one memory port with a loader.
// Optional HALT_ON_NOP_EN: a captured zero word stops fetch until redirect or reset.
module instr_fetch_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_q,
  output logic              halted
);

  typedef enum logic {
    FETCH = 1'b0,
    LOAD  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_pc;
  logic              pend;
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [DATA_W-1:0] ld_data_q;
  logic [ADDR_W-1:0] fifo_pc  [2];
  logic [DATA_W-1:0] fifo_ins [2];

  logic              is_load;
  logic              pop;
  logic [1:0]        remain;
  logic [1:0]        occ;
  logic              cap;
  logic              cap_ok;
  logic              cap_nop;
  logic              nop_word;
  logic              halt_now;
  logic              issue;
  logic              flush;
  logic [ADDR_W-1:0] restore_pc;

  assign is_load = (state == LOAD);
  assign pop     = (count != 2'd0) & id_ready;
  assign remain  = count - {1'b0, pop};
  assign occ     = remain + {1'b0, pend};
  assign flush   = redir_valid | is_load;
  assign cap     = pend & ~is_load & ~redir_valid;

`ifdef HALT_ON_NOP_EN
  logic halt_q;
  assign nop_word = (mem_q == '0);
  assign halt_now = halt_q;
  assign halted   = halt_q;
`else
  assign nop_word = 1'b0;
  assign halt_now = 1'b0;
  assign halted   = 1'b0;
`endif

  assign cap_ok  = cap & ~nop_word;
  assign cap_nop = cap & nop_word;
  assign issue   = ~is_load & ~ld_req & ~redir_valid
                 & ~halt_now & ~cap_nop & (occ <= 2'd1);

  assign mem_wren    = is_load & ~Reset;
  assign ld_gnt      = mem_wren;
  assign mem_address = is_load ? ld_addr_q : pc;
  assign mem_din     = ld_data_q;

  assign if_valid = (count != 2'd0);
  assign if_pc    = fifo_pc[rd_ptr];
  assign if_instr = fifo_ins[rd_ptr];

  // PC to resume from after a load: oldest entry not yet consumed
  always_comb begin
    restore_pc = pc;
    unique case (1'b1)
      (remain != 2'd0):        restore_pc = fifo_pc[rd_ptr ^ pop];
      (remain == 2'd0) & pend: restore_pc = pend_pc;
      (remain == 2'd0) & ~pend: restore_pc = pc;
      default:                 restore_pc = pc;
    endcase
  end

  // Port FSM, PC, pending read and buffer occupancy
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pend      <= 1'b0;
      pend_pc   <= RESET_PC;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
    end else begin
      state <= ld_req ? LOAD : FETCH;
      if (ld_req) begin
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        pend   <= 1'b0;
        pc     <= redir_valid ? redir_pc : restore_pc;
      end else begin
        count  <= count - {1'b0, pop} + {1'b0, cap_ok};
        rd_ptr <= rd_ptr ^ pop;
        wr_ptr <= wr_ptr ^ cap_ok;
        pend   <= issue;
        if (issue) begin
          pend_pc <= pc;
          pc      <= pc + ADDR_W'(1);
        end
      end
    end
  end

  // Buffer payload, written when a read result is captured
  always_ff @(posedge Clock) begin
    if (~Reset & cap_ok) begin
      fifo_pc[wr_ptr]  <= pend_pc;
      fifo_ins[wr_ptr] <= mem_q;
    end
  end

`ifdef HALT_ON_NOP_EN
  // Halt latch: set on a captured zero word, cleared by redirect
  always_ff @(posedge Clock) begin
    if (Reset) begin
      halt_q <= 1'b0;
    end else if (redir_valid) begin
      halt_q <= 1'b0;
    end else if (cap_nop) begin
      halt_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: vector tables, corner sequences and a randomized
// transaction-level model for instr_fetch_ctrl with a 16x16 sync memory.
module tb_instr_fetch_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ld_req = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_gnt;
  logic        redir_valid = 1'b0;
  logic [3:0]  redir_pc = '0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [3:0]  if_pc;
  logic        id_ready = 1'b0;
  logic        mem_wren;
  logic [3:0]  mem_address;
  logic [15:0] mem_din;
  logic [15:0] mem_q;
  logic        halted;

  logic        img_reload = 1'b0;
  logic [15:0] mem   [16];
  logic [15:0] image [16];
  logic [15:0] shadow [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [3:0]  rpc;
    logic        lr;
    logic [3:0]  la;
    logic [15:0] ld;
    logic        ev;
    logic [3:0]  epc;
    logic [15:0] ei;
    logic        eg;
    logic        ca;
    logic [3:0]  ea;
    logic        eh;
  } vec_t;

  vec_t tv[$];

  always #5 Clock = ~Clock;

  instr_fetch_ctrl dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_gnt      (ld_gnt),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .mem_wren    (mem_wren),
    .mem_address (mem_address),
    .mem_din     (mem_din),
    .mem_q       (mem_q),
    .halted      (halted)
  );

  // Instruction memory: 1-cycle synchronous read, image reload for tests
  always @(posedge Clock) begin
    if (img_reload) begin
      for (int i = 0; i < 16; i++) mem[i] <= image[i];
    end else if (mem_wren) begin
      mem[mem_address] <= mem_din;
    end
    mem_q <= mem[mem_address];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic set_default_image();
    for (int i = 0; i < 16; i++) image[i] = 16'h0000;
    image[0] = 16'h40A0;
    image[1] = 16'h60A0;
    for (int i = 2; i <= 5; i++) image[i] = 16'h40A0;
    image[6] = 16'h60A0;
  endtask

  task automatic reset_dut();
    @(posedge Clock); #1;
    Reset = 1'b1; img_reload = 1'b1;
    ld_req = 1'b0; redir_valid = 1'b0; id_ready = 1'b0;
    @(posedge Clock); #1;
    img_reload = 1'b0;
  endtask

  function automatic vec_t mk(input logic rdy, input logic ev,
                              input logic [3:0] epc, input logic [15:0] ei,
                              input logic eh);
    vec_t v;
    v.rdy = rdy; v.rv = 1'b0; v.rpc = '0;
    v.lr = 1'b0; v.la = '0; v.ld = '0;
    v.ev = ev; v.epc = epc; v.ei = ei;
    v.eg = 1'b0; v.ca = 1'b0; v.ea = '0; v.eh = eh;
    return v;
  endfunction

  task automatic run_table(input string tag);
    set_default_image();
    reset_dut();
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge Clock); #1;
      Reset = 1'b0;
      id_ready = tv[i].rdy;
      redir_valid = tv[i].rv; redir_pc = tv[i].rpc;
      ld_req = tv[i].lr; ld_addr = tv[i].la; ld_data = tv[i].ld;
      @(negedge Clock);
      chk($sformatf("%s[%0d].valid", tag, i), 32'(if_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("%s[%0d].pc", tag, i), 32'(if_pc), 32'(tv[i].epc));
        chk($sformatf("%s[%0d].instr", tag, i), 32'(if_instr), 32'(tv[i].ei));
      end
      chk($sformatf("%s[%0d].gnt", tag, i), 32'(ld_gnt), 32'(tv[i].eg));
      chk($sformatf("%s[%0d].wren", tag, i), 32'(mem_wren), 32'(tv[i].eg));
      chk($sformatf("%s[%0d].halted", tag, i), 32'(halted), 32'(tv[i].eh));
      if (tv[i].ca)
        chk($sformatf("%s[%0d].addr", tag, i), 32'(mem_address), 32'(tv[i].ea));
    end
    id_ready = 1'b0; redir_valid = 1'b0; ld_req = 1'b0;
    tv.delete();
  endtask

  initial begin
    vec_t v;
    int k;
    int n_exp;
    int pops;
    logic [3:0] exp_pc;
    logic prev_lr, prev_rst, exp_gnt, hold;
    logic [3:0] prev_la, hold_pc;
    logic [15:0] prev_ld, hold_ins;

    // Table A: reset, stream, stall cycles 3-6, resume
    v = mk(1, 0, 0, 0, 0); v.ca = 1; v.ea = 4'd0; tv.push_back(v);
    v = mk(1, 0, 0, 0, 0); v.ca = 1; v.ea = 4'd1; tv.push_back(v);
    tv.push_back(mk(1, 1, 0, 16'h40A0, 0));
    tv.push_back(mk(0, 1, 1, 16'h60A0, 0));
    tv.push_back(mk(0, 1, 1, 16'h60A0, 0));
    tv.push_back(mk(0, 1, 1, 16'h60A0, 0));
    tv.push_back(mk(0, 1, 1, 16'h60A0, 0));
    tv.push_back(mk(1, 1, 1, 16'h60A0, 0));
    tv.push_back(mk(1, 1, 2, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 3, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 4, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 5, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 6, 16'h60A0, 0));
`ifdef HALT_ON_NOP_EN
    tv.push_back(mk(1, 0, 0, 0, 1));
`else
    tv.push_back(mk(1, 1, 7, 16'h0000, 0));
`endif
    run_table("stall");

    // Table B: redirect to 5 in cycle 4, redirect to 0 in cycle 9
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 1, 16'h60A0, 0));
    v = mk(1, 1, 2, 16'h40A0, 0); v.rv = 1; v.rpc = 4'd5; tv.push_back(v);
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 5, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 6, 16'h60A0, 0));
`ifdef HALT_ON_NOP_EN
    v = mk(1, 0, 0, 0, 1);
`else
    v = mk(1, 1, 7, 16'h0000, 0);
`endif
    v.rv = 1; v.rpc = 4'd0; tv.push_back(v);
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 1, 16'h60A0, 0));
    run_table("redir");

    // Table C: loader writes 6000 to address 3 while streaming
    tv.push_back(mk(1, 0, 0, 0, 0));
    v = mk(1, 0, 0, 0, 0); v.lr = 1; v.la = 4'd3; v.ld = 16'h6000;
    tv.push_back(v);
    v = mk(1, 1, 0, 16'h40A0, 0); v.eg = 1; v.ca = 1; v.ea = 4'd3;
    tv.push_back(v);
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 1, 16'h60A0, 0));
    tv.push_back(mk(1, 1, 2, 16'h40A0, 0));
    tv.push_back(mk(1, 1, 3, 16'h6000, 0));
    tv.push_back(mk(1, 1, 4, 16'h40A0, 0));
    run_table("load");

    // Free run from reset: wrap through zero words, or halt on first zero
    set_default_image();
    reset_dut();
    @(posedge Clock); #1;
    Reset = 1'b0; id_ready = 1'b1;
`ifdef HALT_ON_NOP_EN
    n_exp = 7;
`else
    n_exp = 20;
`endif
    k = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge Clock);
      if (if_valid) begin
        chk($sformatf("freerun[%0d].pc", k), 32'(if_pc), k % 16);
        chk($sformatf("freerun[%0d].instr", k), 32'(if_instr),
            32'(image[k % 16]));
        k++;
      end
      if (k == n_exp) break;
      @(posedge Clock); #1;
    end
    chk("freerun.delivered", k, n_exp);
`ifdef HALT_ON_NOP_EN
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge Clock);
      chk($sformatf("halt.idle[%0d]", cyc), 32'(if_valid), 0);
    end
    chk("halt.flag", 32'(halted), 1);
`endif

    // Reset arriving in the cycle a write would be performed
    set_default_image();
    reset_dut();
    @(posedge Clock); #1;
    Reset = 1'b0; id_ready = 1'b1;
    ld_req = 1'b1; ld_addr = 4'd3; ld_data = 16'h1234;
    @(posedge Clock); #1;
    Reset = 1'b1; ld_req = 1'b0;
    @(negedge Clock);
    chk("rstload.gnt", 32'(ld_gnt), 0);
    chk("rstload.wren", 32'(mem_wren), 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("rstload.gnt2", 32'(ld_gnt), 0);
    chk("rstload.valid", 32'(if_valid), 0);
    chk("rstload.mem3", 32'(mem[3]), 32'h40A0);

    // Randomized traffic against a transaction-level model
    for (int i = 0; i < 16; i++) begin
      image[i] = 16'($urandom_range(1, 16'hFFFF));
      shadow[i] = image[i];
    end
    reset_dut();
    exp_pc = 4'd0; pops = 0; hold = 1'b0;
    prev_lr = 1'b0; prev_rst = 1'b1; prev_la = '0; prev_ld = '0;
    hold_pc = '0; hold_ins = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clock); #1;
      Reset = (cyc == 1500);
      if (Reset) begin
        id_ready = 1'b0; redir_valid = 1'b0; ld_req = 1'b0;
      end else begin
        id_ready = ($urandom_range(0, 9) < 7);
        redir_valid = ($urandom_range(0, 19) == 0);
        redir_pc = 4'($urandom_range(0, 15));
        ld_req = ($urandom_range(0, 11) == 0) || (cyc == 1499);
        ld_addr = 4'($urandom_range(0, 15));
        ld_data = 16'($urandom_range(1, 16'hFFFF));
      end
      @(negedge Clock);
      exp_gnt = prev_lr & ~prev_rst & ~Reset;
      chk("rand.gnt", 32'(ld_gnt), 32'(exp_gnt));
      chk("rand.wren", 32'(mem_wren), 32'(exp_gnt));
      if (exp_gnt) begin
        chk("rand.waddr", 32'(mem_address), 32'(prev_la));
        chk("rand.wdata", 32'(mem_din), 32'(prev_ld));
      end
      chk("rand.halted", 32'(halted), 0);
      if (hold) begin
        chk("rand.hold.valid", 32'(if_valid), 1);
        chk("rand.hold.pc", 32'(if_pc), 32'(hold_pc));
        chk("rand.hold.instr", 32'(if_instr), 32'(hold_ins));
      end
      if (!Reset && if_valid && id_ready) begin
        chk("rand.pc", 32'(if_pc), 32'(exp_pc));
        chk("rand.instr", 32'(if_instr), 32'(shadow[exp_pc]));
        exp_pc = exp_pc + 4'd1;
        pops++;
      end
      hold = !Reset && if_valid && !id_ready && !redir_valid && !exp_gnt;
      hold_pc = if_pc; hold_ins = if_instr;
      if (redir_valid && !Reset) exp_pc = redir_pc;
      if (exp_gnt) shadow[prev_la] = prev_ld;
      if (Reset) exp_pc = 4'd0;
      prev_lr = ld_req; prev_la = ld_addr; prev_ld = ld_data;
      prev_rst = Reset;
    end
    chk("rand.progress", 32'(pops >= 500), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
